// File: rtl/turbo_pkg.sv
// Shared constants for the turbo encoder: code polynomials, tail length,
// control-FSM state encodings and the RSC encoder debug view.
package turbo_pkg;

  localparam int TURBO_MEM = 3;

  // Generator coefficients, MSB = D^0: feedback 1+D^2+D^3, feed-forward 1+D+D^3.
  localparam logic [TURBO_MEM:0] G_FB = 4'b1011;
  localparam logic [TURBO_MEM:0] G_FF = 4'b1101;

  localparam logic [1:0] WAIT      = 2'd0;
  localparam logic [1:0] ENCODE    = 2'd3;
  localparam logic [1:0] TERMINATE = 2'd2;

  typedef struct packed {
    logic [TURBO_MEM-1:0] s;         // {s1, s2, s3}
    logic [1:0]           tail_cnt;
  } rsc_dbg_t;

endpackage

// File: rtl/rsc_encoder_if.sv
// Strobe and result bundle between the turbo control FSM (master) and an RSC encoder (slave).
interface rsc_encoder_if #(
  parameter int CNT_W = 9
);
  logic             clr;
  logic             enable;
  logic             trellis_enable;
  logic             data_in;
  logic             sys_out;
  logic             par_out;
  logic             out_valid;
  logic             tail_valid;
  logic             tail_done;
  logic [CNT_W-1:0] bit_count;
  logic             proto_err;

  // out_valid qualifies sys_out/par_out for exactly one cycle; there is no
  // ready, so the consumer must accept every valid beat as it appears.
  modport master (
    output clr, enable, trellis_enable, data_in,
    input  sys_out, par_out, out_valid, tail_valid, tail_done, bit_count, proto_err
  );

  modport slave (
    input  clr, enable, trellis_enable, data_in,
    output sys_out, par_out, out_valid, tail_valid, tail_done, bit_count, proto_err
  );
endinterface

// File: rtl/rsc_step.sv
// One trellis step of the 8-state RSC code; purely combinational so the
// interleaved constituent encoder can reuse it.
module rsc_step
  import turbo_pkg::*;
(
  input  logic [TURBO_MEM-1:0] state,
  input  logic                 data_bit,
  input  logic                 term,
  output logic [TURBO_MEM-1:0] next_state,
  output logic                 sys,
  output logic                 par
);

  logic fb;
  logic a;

  always_comb begin
    fb = ^(state & G_FB[TURBO_MEM-1:0]);
    // During termination the input bit equals the feedback, forcing a to 0.
    sys = term ? fb : data_bit;
    a   = sys ^ fb;
    par = (a & G_FF[TURBO_MEM]) ^ (^(state & G_FF[TURBO_MEM-1:0]));
    next_state = {a, state[TURBO_MEM-1:1]};
  end

endmodule

// File: rtl/rsc_encoder.sv
// RSC constituent encoder: registered systematic/parity output, trellis
// termination with tail counter, saturating bit counter and sticky error flag.
module rsc_encoder
  import turbo_pkg::*;
#(
  parameter int MEM   = TURBO_MEM,
  parameter int CNT_W = 9
) (
  input  logic          clk,
  input  logic          reset,
  rsc_encoder_if.slave  bus,
  output rsc_dbg_t      dbg
);

  logic [TURBO_MEM-1:0] s_q, s_d, step_next;
  logic [1:0]           tail_q, tail_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic sys_q, sys_d, par_q, par_d;
  logic ov_q, ov_d, tv_q, tv_d, td_q, td_d, err_q, err_d;
  logic step_sys, step_par;

  rsc_step u_step (
    .state      (s_q),
    .data_bit   (bus.data_in),
    .term       (bus.trellis_enable),
    .next_state (step_next),
    .sys        (step_sys),
    .par        (step_par)
  );

  always_comb begin
    s_d    = s_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    sys_d  = sys_q;
    par_d  = par_q;
    ov_d   = 1'b0;
    tv_d   = 1'b0;
    td_d   = 1'b0;
    err_d  = err_q;
    if (bus.trellis_enable) begin
      if (bus.enable) err_d = 1'b1;
      // Past MEM tail bits the FSM may keep the strobe high; freeze quietly.
      if (tail_q < 2'(MEM)) begin
        s_d    = step_next;
        sys_d  = step_sys;
        par_d  = step_par;
        ov_d   = 1'b1;
        tv_d   = 1'b1;
        tail_d = tail_q + 2'd1;
        if (tail_q == 2'(MEM - 1)) begin
          td_d = 1'b1;
          if (step_next != '0) err_d = 1'b1;
        end
      end
    end else begin
      tail_d = '0;
      if (bus.enable) begin
        s_d   = step_next;
        sys_d = step_sys;
        par_d = step_par;
        ov_d  = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      s_q    <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      sys_q  <= 1'b0;
      par_q  <= 1'b0;
      ov_q   <= 1'b0;
      tv_q   <= 1'b0;
      td_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      sys_q  <= sys_d;
      par_q  <= par_d;
      ov_q   <= ov_d;
      tv_q   <= tv_d;
      td_q   <= td_d;
      err_q  <= err_d;
    end
  end

  assign bus.sys_out    = sys_q;
  assign bus.par_out    = par_q;
  assign bus.out_valid  = ov_q;
  assign bus.tail_valid = tv_q;
  assign bus.tail_done  = td_q;
  assign bus.bit_count  = cnt_q;
  assign bus.proto_err  = err_q;
  assign dbg.s          = s_q;
  assign dbg.tail_cnt   = tail_q;

endmodule

// File: tb/tb_rsc_encoder.sv
// Self-checking bench for rsc_encoder: directed impulse/tail/overlap/abort
// vectors plus reference-model frames scored through an expected queue.
module tb_rsc_encoder;
  import turbo_pkg::*;

  localparam int CNT_W = 9;

  logic     clk = 1'b0;
  logic     reset = 1'b1;
  rsc_dbg_t dbg;

  rsc_encoder_if #(.CNT_W(CNT_W)) bus ();

  rsc_encoder #(.MEM(3), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dbg   (dbg)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];          // {sys, par} per valid output beat
  logic       m_s1, m_s2, m_s3;  // reference trellis state
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of strobes, then sample 1 time unit after the edge.
  task automatic cycle(input logic c, input logic en, input logic te, input logic d);
    bus.clr            = c;
    bus.enable         = en;
    bus.trellis_enable = te;
    bus.data_in        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_enc(input logic d);
    logic a;
    a = d ^ m_s2 ^ m_s3;
    exp_q.push_back({d, a ^ m_s1 ^ m_s3});
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = a;
    if (m_cnt < 511) m_cnt++;
  endtask

  task automatic model_tail();
    exp_q.push_back({m_s2 ^ m_s3, m_s1 ^ m_s3});
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = 1'b0;
  endtask

  task automatic score(input string tag);
    logic [1:0] e;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) check({tag, "_extra_beat"}, 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check(tag, {bus.sys_out, bus.par_out}, e);
      end
    end
  endtask

  task automatic run_frame(input int len, input string tag);
    logic d;
    for (int i = 0; i < len; i++) begin
      d = 1'($urandom_range(0, 1));
      model_enc(d);
      cycle(1'b0, 1'b1, 1'b0, d);
      score(tag);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 3) model_tail();
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      score({tag, "_tail"});
      check({tag, "_tail_done"}, bus.tail_done, (i == 2));
    end
    check({tag, "_final_state"}, dbg.s, 3'b000);
    check({tag, "_bit_count"}, bus.bit_count, m_cnt);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
    check({tag, "_proto_err"}, bus.proto_err, 1'b0);
  endtask

  logic imp_d[4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic tail_sys[3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    bus.clr = 1'b0; bus.enable = 1'b0; bus.trellis_enable = 1'b0; bus.data_in = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_sys_par", {bus.sys_out, bus.par_out}, 2'b00);
    check("rst_tail_flags", {bus.tail_valid, bus.tail_done}, 2'b00);
    check("rst_bit_count", bus.bit_count, 0);
    check("rst_proto_err", bus.proto_err, 1'b0);
    check("rst_state", dbg.s, 3'b000);
    check("rst_tail_cnt", dbg.tail_cnt, 2'd0);
    reset = 1'b0;

    // Impulse response
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, imp_d[i]);
      check($sformatf("imp_sys%0d", i), bus.sys_out, imp_d[i]);
      check($sformatf("imp_par%0d", i), bus.par_out, 1'b1);
      check($sformatf("imp_valid%0d", i), {bus.out_valid, bus.tail_valid}, 2'b10);
    end
    check("imp_state", dbg.s, 3'b110);
    check("imp_bit_count", bus.bit_count, 4);

    // Termination held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      if (i < 3) begin
        check($sformatf("tail_sys%0d", i), bus.sys_out, tail_sys[i]);
        check($sformatf("tail_par%0d", i), bus.par_out, 1'b1);
        check($sformatf("tail_valid%0d", i), {bus.out_valid, bus.tail_valid}, 2'b11);
      end else begin
        check($sformatf("tail_hold_valid%0d", i), {bus.out_valid, bus.tail_valid}, 2'b00);
      end
      check($sformatf("tail_done%0d", i), bus.tail_done, (i == 2));
    end
    check("tail_state", dbg.s, 3'b000);
    check("tail_proto_err", bus.proto_err, 1'b0);
    check("tail_bit_count_kept", bus.bit_count, 4);

    // Idle holds outputs
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("idle_valid", {bus.out_valid, bus.tail_valid, bus.tail_done}, 3'b000);
    check("idle_hold_sys_par", {bus.sys_out, bus.par_out}, 2'b11);
    check("idle_state", dbg.s, 3'b000);

    // Encode after termination without clr
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("post_term_sys_par", {bus.sys_out, bus.par_out}, 2'b11);
    check("post_term_state", dbg.s, 3'b100);
    check("post_term_bit_count", bus.bit_count, 5);

    // Overlap: terminate wins, sticky error
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("ovl_sys_par", {bus.sys_out, bus.par_out}, 2'b01);
    check("ovl_valid", {bus.out_valid, bus.tail_valid}, 2'b11);
    check("ovl_proto_err", bus.proto_err, 1'b1);
    check("ovl_state", dbg.s, 3'b010);
    check("ovl_bit_count", bus.bit_count, 5);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovl_idle_err", bus.proto_err, 1'b1);
    check("ovl_rearm", dbg.tail_cnt, 2'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("ovl_enc_sys_par", {bus.sys_out, bus.par_out}, 2'b01);
    check("ovl_enc_state", dbg.s, 3'b101);
    check("ovl_sticky", bus.proto_err, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("clr_proto_err", bus.proto_err, 1'b0);
    check("clr_state_count", {dbg.s, bus.bit_count}, 0);
    check("clr_sys_par_valid", {bus.sys_out, bus.par_out, bus.out_valid}, 3'b000);

    // Reset abort at frame bit 100
    model_clear();
    for (int i = 0; i < 100; i++) begin
      logic d;
      d = 1'($urandom_range(0, 1));
      model_enc(d);
      cycle(1'b0, 1'b1, 1'b0, d);
      score("abort_pre");
    end
    check("abort_pre_count", bus.bit_count, 100);
    reset = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    check("abort_outputs", {bus.sys_out, bus.par_out, bus.out_valid, bus.tail_valid,
                            bus.tail_done, bus.proto_err}, 6'b0);
    check("abort_state", dbg.s, 3'b000);
    check("abort_bit_count", bus.bit_count, 0);

    // clr abort mid-frame
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_abort_valid", {bus.out_valid, bus.tail_valid}, 2'b00);
    check("clr_abort_state_count", {dbg.s, bus.bit_count}, 0);

    // Saturation
    model_clear();
    for (int i = 0; i < 600; i++) begin
      logic d;
      d = 1'($urandom_range(0, 1));
      model_enc(d);
      cycle(1'b0, 1'b1, 1'b0, d);
      score("sat_enc");
      if (i == 510) check("sat_reach_511", bus.bit_count, 511);
    end
    check("sat_bit_count", bus.bit_count, 511);
    check("sat_still_valid", bus.out_valid, 1'b1);
    check("sat_state", dbg.s, {m_s1, m_s2, m_s3});
    for (int i = 0; i < 3; i++) begin
      model_tail();
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      score("sat_tail");
    end
    check("sat_queue_drained", exp_q.size(), 0);

    // Random frames separated by clr
    for (int f = 0; f < 3; f++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      model_clear();
      run_frame($urandom_range(40, 511), $sformatf("clr_frame%0d", f));
    end

    // Random frames back to back
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    model_clear();
    for (int f = 0; f < 3; f++) begin
      run_frame($urandom_range(40, 511), $sformatf("b2b_frame%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
